// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator car controller.
//   state_e    : controller state encoding
//   dir_e      : travel direction (DIR_UP / DIR_DN)
//   MODE_*     : 2-bit mode codes shared with the mode/status display decoder
//   mode_of()  : maps a controller state to its display mode code
package elevator_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StMoveUp = 3'd1,
    StMoveDn = 3'd2,
    StDoor   = 3'd3,
    StMaint  = 3'd4
  } state_e;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_e;

  localparam logic [1:0] MODE_IDLE  = 2'b00;
  localparam logic [1:0] MODE_MOVE  = 2'b01;
  localparam logic [1:0] MODE_DOOR  = 2'b10;
  localparam logic [1:0] MODE_MAINT = 2'b11;

  function automatic logic [1:0] mode_of(input state_e s);
    logic [1:0] m;
    case (s)
      StMoveUp, StMoveDn: m = MODE_MOVE;
      StDoor:             m = MODE_DOOR;
      StMaint:            m = MODE_MAINT;
      default:            m = MODE_IDLE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/elev_timer.sv
// Loadable down-counter used for floor transit and door dwell timing.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset (count -> 0)
//   load  : load 'value' on this edge (takes priority over counting)
//   value : reload value
//   zero  : count is zero; the counter holds at zero
module elev_timer
  import elevator_pkg::*;
#(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= value;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/elevator_ctrl.sv
// Elevator car-sequencing controller with SCAN scheduling.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   req       : per-floor call requests, sampled every edge
//   maint     : maintenance request
//   floor     : current floor
//   motor_up  : car travelling up
//   motor_dn  : car travelling down
//   door_open : door open command
//   Q1, Q0    : mode code for the display decoder (idle/move/door/maint)
// The car keeps its direction while calls lie ahead and reverses otherwise.
module elevator_ctrl
  import elevator_pkg::*;
#(
  parameter int unsigned N_FLOORS      = 4,
  parameter int unsigned TRAVEL_CYCLES = 4,
  parameter int unsigned DOOR_CYCLES   = 3,
  parameter int unsigned FW            = $clog2(N_FLOORS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_FLOORS-1:0] req,
  input  logic                maint,
  output logic [FW-1:0]       floor,
  output logic                motor_up,
  output logic                motor_dn,
  output logic                door_open,
  output logic                Q1,
  output logic                Q0
);

  localparam int unsigned TMax = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int unsigned TW   = (TMax > 1) ? $clog2(TMax) : 1;
  localparam logic [TW-1:0] TravelLoad = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] DoorLoad   = TW'(DOOR_CYCLES - 1);

  state_e              state_q, state_d;
  dir_e                dir_q, dir_d;
  logic [FW-1:0]       floor_q, floor_d, arr;
  logic [N_FLOORS-1:0] pending_q, pending_d, pend_eff;
  logic                tmr_load, tmr_zero;
  logic [TW-1:0]       tmr_val;
  logic                clr_one, clr_all;
  logic [FW-1:0]       clr_idx;
  logic                above, below, arr_ahead, go_up, go_dn;

  function automatic logic any_above(input logic [N_FLOORS-1:0] m, input logic [FW-1:0] f);
    logic hit;
    hit = 1'b0;
    for (int unsigned i = 0; i < N_FLOORS; i++) begin
      if (m[i] && (i > 32'(f))) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic any_below(input logic [N_FLOORS-1:0] m, input logic [FW-1:0] f);
    logic hit;
    hit = 1'b0;
    for (int unsigned i = 0; i < N_FLOORS; i++) begin
      if (m[i] && (i < 32'(f))) hit = 1'b1;
    end
    return hit;
  endfunction

  elev_timer #(
    .W(TW)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (tmr_load),
    .value(tmr_val),
    .zero (tmr_zero)
  );

  always_comb begin
    // Requests arriving this edge count as calls for every decision.
    pend_eff  = pending_q | req;
    above     = any_above(pend_eff, floor_q);
    below     = any_below(pend_eff, floor_q);
    // Current direction wins when calls exist on both sides.
    go_up     = above && ((dir_q == DIR_UP) || !below);
    go_dn     = below && ((dir_q == DIR_DN) || !above);
    arr       = (state_q == StMoveDn) ? floor_q - FW'(1) : floor_q + FW'(1);
    arr_ahead = (state_q == StMoveDn) ? any_below(pend_eff, arr) : any_above(pend_eff, arr);

    state_d  = state_q;
    dir_d    = dir_q;
    floor_d  = floor_q;
    tmr_load = 1'b0;
    tmr_val  = TravelLoad;
    clr_one  = 1'b0;
    clr_all  = 1'b0;
    clr_idx  = floor_q;

    unique case (state_q)
      StIdle: begin
        if (maint) begin
          state_d = StMaint;
          clr_all = 1'b1;
        end else if (pend_eff[floor_q]) begin
          state_d  = StDoor;
          tmr_load = 1'b1;
          tmr_val  = DoorLoad;
          clr_one  = 1'b1;
        end else if (go_up) begin
          state_d  = StMoveUp;
          dir_d    = DIR_UP;
          tmr_load = 1'b1;
        end else if (go_dn) begin
          state_d  = StMoveDn;
          dir_d    = DIR_DN;
          tmr_load = 1'b1;
        end
      end

      StMoveUp, StMoveDn: begin
        if (tmr_zero) begin
          floor_d = arr;
          if (pend_eff[arr]) begin
            state_d  = StDoor;
            tmr_load = 1'b1;
            tmr_val  = DoorLoad;
            clr_one  = 1'b1;
            clr_idx  = arr;
          end else if (arr_ahead) begin
            tmr_load = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end

      StDoor: begin
        // A call for this floor while the door is open extends the dwell.
        if (req[floor_q]) begin
          tmr_load = 1'b1;
          tmr_val  = DoorLoad;
        end else if (tmr_zero) begin
          if (maint) begin
            state_d = StMaint;
            clr_all = 1'b1;
          end else if (go_up) begin
            state_d  = StMoveUp;
            dir_d    = DIR_UP;
            tmr_load = 1'b1;
          end else if (go_dn) begin
            state_d  = StMoveDn;
            dir_d    = DIR_DN;
            tmr_load = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end

      StMaint: begin
        if (!maint) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase

    pending_d = pending_q;
    if (state_q != StMaint) begin
      pending_d = pending_q | req;
      if (state_q == StDoor) pending_d[floor_q] = pending_q[floor_q];
    end
    // Clearing on door entry overrides a same-edge request for that floor.
    if (clr_one) pending_d[clr_idx] = 1'b0;
    if (clr_all) pending_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      dir_q     <= DIR_UP;
      floor_q   <= '0;
      pending_q <= '0;
      motor_up  <= 1'b0;
      motor_dn  <= 1'b0;
      door_open <= 1'b0;
      Q1        <= 1'b0;
      Q0        <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      floor_q   <= floor_d;
      pending_q <= pending_d;
      motor_up  <= (state_d == StMoveUp);
      motor_dn  <= (state_d == StMoveDn);
      door_open <= (state_d == StDoor);
      {Q1, Q0}  <= mode_of(state_d);
    end
  end

  assign floor = floor_q;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Self-checking bench for elevator_ctrl (4 floors, 4-cycle transit, 3-cycle dwell).
module tb_elevator_ctrl;

  localparam int NF     = 4;
  localparam int TRAVEL = 4;
  localparam int DOOR   = 3;

  localparam logic [1:0] M_IDLE  = 2'd0;
  localparam logic [1:0] M_MOVE  = 2'd1;
  localparam logic [1:0] M_DOOR  = 2'd2;
  localparam logic [1:0] M_MAINT = 2'd3;

  logic          clk;
  logic          rst_n;
  logic [NF-1:0] req;
  logic          maint;
  logic [1:0]    floor;
  logic          motor_up, motor_dn, door_open, Q1, Q0;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  elevator_ctrl #(
    .N_FLOORS     (NF),
    .TRAVEL_CYCLES(TRAVEL),
    .DOOR_CYCLES  (DOOR)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .maint    (maint),
    .floor    (floor),
    .motor_up (motor_up),
    .motor_dn (motor_dn),
    .door_open(door_open),
    .Q1       (Q1),
    .Q0       (Q0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: mode, direction, floor, latched calls, edges left in current segment.
  typedef struct packed {
    logic [1:0]    mode;
    logic          up;
    logic [7:0]    fl;
    logic [NF-1:0] pend;
    logic [7:0]    left;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t model_reset();
    mdl_t r;
    r.mode = M_IDLE;
    r.up   = 1'b1;
    r.fl   = '0;
    r.pend = '0;
    r.left = '0;
    return r;
  endfunction

  function automatic bit calls_beyond(input logic [NF-1:0] eff, input int f, input bit up);
    bit hit;
    hit = 0;
    for (int i = 0; i < NF; i++) begin
      if (eff[i] && (up ? (i > f) : (i < f))) hit = 1;
    end
    return hit;
  endfunction

  function automatic mdl_t depart(input mdl_t s, input logic [NF-1:0] eff, input int f);
    mdl_t n;
    n = s;
    if (calls_beyond(eff, f, s.up)) begin
      n.mode = M_MOVE;
      n.left = 8'(TRAVEL);
    end else if (calls_beyond(eff, f, !s.up)) begin
      n.mode = M_MOVE;
      n.up   = !s.up;
      n.left = 8'(TRAVEL);
    end else begin
      n.mode = M_IDLE;
    end
    return n;
  endfunction

  function automatic mdl_t model_step(input mdl_t s, input logic [NF-1:0] r, input logic mt);
    mdl_t          n;
    logic [NF-1:0] eff;
    int            f;
    n   = s;
    eff = s.pend | r;
    f   = int'(s.fl);
    if (s.mode != M_MAINT) n.pend = s.pend | r;
    case (s.mode)
      M_IDLE: begin
        if (mt) begin
          n.mode = M_MAINT;
          n.pend = '0;
        end else if (eff[f]) begin
          n.mode    = M_DOOR;
          n.left    = 8'(DOOR);
          n.pend[f] = 1'b0;
        end else begin
          n = depart(n, eff, f);
        end
      end
      M_MOVE: begin
        if (s.left > 1) begin
          n.left = s.left - 8'd1;
        end else begin
          f    = s.up ? f + 1 : f - 1;
          n.fl = 8'(f);
          if (eff[f]) begin
            n.mode    = M_DOOR;
            n.left    = 8'(DOOR);
            n.pend[f] = 1'b0;
          end else if (calls_beyond(eff, f, s.up)) begin
            n.left = 8'(TRAVEL);
          end else begin
            n.mode = M_IDLE;
          end
        end
      end
      M_DOOR: begin
        n.pend[f] = s.pend[f];
        if (r[f]) begin
          n.left = 8'(DOOR);
        end else if (s.left > 1) begin
          n.left = s.left - 8'd1;
        end else if (mt) begin
          n.mode = M_MAINT;
          n.pend = '0;
        end else begin
          n = depart(n, eff, f);
        end
      end
      default: begin
        if (!mt) n.mode = M_IDLE;
      end
    endcase
    return n;
  endfunction

  function automatic logic [6:0] model_obs(input mdl_t s);
    return {s.fl[1:0], (s.mode == M_MOVE) && s.up, (s.mode == M_MOVE) && !s.up,
            s.mode == M_DOOR, s.mode};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else        m <= model_step(m, req, maint);
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if ({floor, motor_up, motor_dn, door_open, Q1, Q0} !== model_obs(m)) begin
        errors++;
        $display("FAIL cycle_outputs t=%0t: got %b expected %b", $time,
                 {floor, motor_up, motor_dn, door_open, Q1, Q0}, model_obs(m));
      end
      checks++;
      if (dut.pending_q !== m.pend) begin
        errors++;
        $display("FAIL cycle_pending t=%0t: got %b expected %b", $time, dut.pending_q, m.pend);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Literal expectations, applied to both the DUT and the model.
  task automatic expect_obs(input string name, input int fl, input bit mu, input bit md,
                            input bit dr, input logic [1:0] q);
    logic [6:0] exp;
    logic [6:0] act;
    exp = {fl[1:0], mu, md, dr, q};
    act = {floor, motor_up, motor_dn, door_open, Q1, Q0};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {floor,up,dn,door,Q} %b expected %b", name, act, exp);
    end
    checks++;
    if (model_obs(m) !== exp) begin
      errors++;
      $display("FAIL model_%s: got %b expected %b", name, model_obs(m), exp);
    end
  endtask

  task automatic expect_pend(input string name, input logic [NF-1:0] exp);
    checks++;
    if (dut.pending_q !== exp) begin
      errors++;
      $display("FAIL %s: got pending %b expected %b", name, dut.pending_q, exp);
    end
    checks++;
    if (m.pend !== exp) begin
      errors++;
      $display("FAIL model_%s: got pending %b expected %b", name, m.pend, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    maint = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    expect_obs("reset", 0, 0, 0, 0, 2'b00);
    expect_pend("reset_pend", 4'b0000);

    // Basic trip 0 -> 2.
    req = 4'b0100; tick(1); req = '0;
    expect_obs("trip_start", 0, 1, 0, 0, 2'b01);
    tick(4); expect_obs("trip_f1", 1, 1, 0, 0, 2'b01);
    tick(4); expect_obs("trip_door", 2, 0, 0, 1, 2'b10);
    tick(3); expect_obs("trip_idle", 2, 0, 0, 0, 2'b00);
    expect_pend("trip_pend", 4'b0000);

    // Asynchronous reset in the middle of an upward transit.
    req = 4'b1000; tick(1); req = '0;
    tick(1);
    #2 rst_n = 1'b0;
    #1 expect_obs("async_reset", 0, 0, 0, 0, 2'b00);
    tick(1);
    rst_n = 1'b1;

    // Intermediate stop on the way 0 -> 3.
    req = 4'b1000; tick(1); req = '0;
    tick(1);
    req = 4'b0010; tick(1); req = '0;
    tick(2); expect_obs("mid_door", 1, 0, 0, 1, 2'b10);
    tick(3); expect_obs("mid_resume", 1, 1, 0, 0, 2'b01);
    tick(8); expect_obs("mid_top", 3, 0, 0, 1, 2'b10);
    tick(3);

    // Reposition to floor 2 heading down.
    req = 4'b0100; tick(1); req = '0;
    tick(7); expect_obs("repos_idle", 2, 0, 0, 0, 2'b00);

    // SCAN: moving up from 2 with call at 3, then a call at 0.
    req = 4'b1000; tick(1); req = '0;
    expect_obs("scan_up", 2, 1, 0, 0, 2'b01);
    req = 4'b0001; tick(1); req = '0;
    tick(3); expect_obs("scan_top", 3, 0, 0, 1, 2'b10);
    tick(3); expect_obs("scan_dn", 3, 0, 1, 0, 2'b01);
    tick(12); expect_obs("scan_bot", 0, 0, 0, 1, 2'b10);
    tick(3); expect_obs("scan_idle", 0, 0, 0, 0, 2'b00);

    // Same-floor call and dwell extension at floor 1.
    req = 4'b0010; tick(1); req = '0;
    tick(7);
    req = 4'b0010; tick(1); req = '0;
    expect_obs("same_door", 1, 0, 0, 1, 2'b10);
    tick(1);
    req = 4'b0010; tick(1); req = '0;
    expect_pend("same_pend", 4'b0000);
    tick(1); expect_obs("same_hold1", 1, 0, 0, 1, 2'b10);
    tick(1); expect_obs("same_hold2", 1, 0, 0, 1, 2'b10);
    tick(1); expect_obs("same_close", 1, 0, 0, 0, 2'b00);

    // Maintenance requested mid-transit.
    req = 4'b1000; tick(1); req = '0;
    maint = 1'b1;
    tick(4); expect_obs("maint_transit", 2, 1, 0, 0, 2'b01);
    tick(4); expect_obs("maint_door", 3, 0, 0, 1, 2'b10);
    req = 4'b0001; tick(1); req = '0;
    expect_pend("maint_latched", 4'b0001);
    tick(2); expect_obs("maint_mode", 3, 0, 0, 0, 2'b11);
    expect_pend("maint_clear", 4'b0000);
    req = 4'b0101; tick(1); req = '0;
    expect_obs("maint_ignore", 3, 0, 0, 0, 2'b11);
    expect_pend("maint_ignore_pend", 4'b0000);
    maint = 1'b0;
    tick(1); expect_obs("maint_exit", 3, 0, 0, 0, 2'b00);
    tick(3); expect_obs("maint_stay_idle", 3, 0, 0, 0, 2'b00);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
